// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port word memory between the instruction-fetch (IF)
// requester and the load/store (LS) requester. One access per cycle.
// Grants are combinational. Memory read data is combinational, so it is
// captured at the grant edge and returned one cycle later.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin on conflict (the port that did not win last wins;
//               with no previous owner, LS wins).
//   undefined : LS has fixed priority. IF is forced to win after MAX_WAIT
//               consecutive refused cycles.
//
// Handshake: a requester raises *_req with stable address and data, and holds
// them until it sees *_gnt high in the same cycle. Grant means the access
// happens at the next rising edge. *_rvalid is high for exactly one cycle
// after that edge.
//
// Ports
//   i_clk, i_reset           clock (rising edge), async active-high reset
//   i_if_req/i_if_addr       IF read request, byte address
//   o_if_gnt                 IF granted this cycle
//   o_if_rvalid/o_if_rdata   IF read response (cycle after grant)
//   i_ls_req/i_ls_addr       LS request, byte address
//   i_ls_wren/i_ls_wdata     LS write enable and write data
//   i_ls_bmask               LS byte-lane mask
//   o_ls_gnt                 LS granted this cycle
//   o_ls_rvalid/o_ls_rdata   LS response (read data, or 0 for a write ack)
//   o_mem_addr               word index of the granted access (0 when idle)
//   o_mem_wdata/o_mem_bmask  write data and byte lanes to memory
//   o_mem_wren               memory write strobe
//   i_mem_rdata              combinational memory read data
//   o_dbg_last_owner         last_owner state: 0 NONE, 1 IF, 2 LS
//   o_dbg_starve_cnt         IF starvation counter
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MEM_AW   = 16,
  parameter int MAX_WAIT = 4,
  localparam int SW      = $clog2(MAX_WAIT + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic              i_ls_wren,
  input  logic [31:0]       i_ls_wdata,
  input  logic [3:0]        i_ls_bmask,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata,
  output logic [1:0]        o_dbg_last_owner,
  output logic [SW-1:0]     o_dbg_starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;

  logic          if_gnt, ls_gnt;
  logic          if_wins_conflict;

  // Only the word-index bits of the addresses reach memory. The byte-offset
  // and upper bits are folded here so they are visibly consumed.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr, i_ls_addr};

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)      owner_d = OWN_IF;
    else if (ls_gnt) owner_d = OWN_LS;

    // Counts cycles IF is refused while it is asking. The count saturates.
    // In round-robin mode the count is still kept but it never forces a win.
    starve_d = starve_q;
    if (!i_if_req || if_gnt)             starve_d = '0;
    else if (starve_q != SW'(MAX_WAIT))  starve_d = starve_q + SW'(1);

    if_rvalid_d = if_gnt;
    ls_rvalid_d = ls_gnt;
    if_rdata_d  = if_gnt ? i_mem_rdata : if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if (ls_gnt) ls_rdata_d = i_ls_wren ? 32'h0 : i_mem_rdata;
  end

  // Output logic: arbitration and memory-side muxing
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if_wins_conflict = (owner_q == OWN_LS);
`else
    if_wins_conflict = (starve_q == SW'(MAX_WAIT));
`endif
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!i_reset) begin
      if (i_if_req && i_ls_req) begin
        if_gnt = if_wins_conflict;
        ls_gnt = !if_wins_conflict;
      end else begin
        if_gnt = i_if_req;
        ls_gnt = i_ls_req;
      end
    end

    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    if (if_gnt) begin
      o_mem_addr = i_if_addr[MEM_AW+1:2];
    end else if (ls_gnt) begin
      o_mem_addr  = i_ls_addr[MEM_AW+1:2];
      o_mem_wdata = i_ls_wdata;
      o_mem_wren  = i_ls_wren;
      o_mem_bmask = i_ls_wren ? i_ls_bmask : 4'h0;
    end
  end

  assign o_if_gnt         = if_gnt;
  assign o_ls_gnt         = ls_gnt;
  assign o_if_rvalid      = if_rvalid_q;
  assign o_ls_rvalid      = ls_rvalid_q;
  assign o_if_rdata       = if_rdata_q;
  assign o_ls_rdata       = ls_rdata_q;
  assign o_dbg_last_owner = owner_q;
  assign o_dbg_starve_cnt = starve_q;

endmodule
